// File: rtl/z80_bus_ctrl.sv
// Z80 bus-cycle controller for the T35 SBC: decodes memory/I/O cycles, drives the
// one-hot chip selects and WAIT, and owns the boot-ROM overlay enable latch.
module z80_bus_ctrl #(
  parameter logic [15:0] ROM_TOP      = 16'h0FFF,
  parameter int unsigned ROM_WAIT     = 1,
  parameter int unsigned RAM_WAIT     = 0,
  parameter int unsigned IO_TIMEOUT   = 255,
  parameter logic [7:0]  ROM_DIS_PORT = 8'hE0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] addr,
  input  logic        mreq_n,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic        m1_n,
  input  logic        s100_rdy,
  output logic        rom_cs,
  output logic        ram_cs,
  output logic        inPortcon_cs,
  output logic        outPortcon_cs,
  output logic        wait_n,
  output logic        rom_enabled,
  output logic        timeout_err
);

  localparam int unsigned WCNT_W = 4;
  localparam int unsigned IOCNT_W = 8;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COUNT   = 2'd1;
  localparam logic [1:0] S_IO_WAIT = 2'd2;
  localparam logic [1:0] S_HOLD    = 2'd3;

  localparam logic [WCNT_W-1:0]  ROM_WAIT_C = WCNT_W'(ROM_WAIT);
  localparam logic [WCNT_W-1:0]  RAM_WAIT_C = WCNT_W'(RAM_WAIT);
  localparam logic [IOCNT_W-1:0] IO_TMO_C   = IOCNT_W'(IO_TIMEOUT);

  logic [1:0]         r_state, w_state_nxt;
  logic [WCNT_W-1:0]  r_wcnt, w_wcnt_nxt;
  logic [IOCNT_W-1:0] r_iocnt, w_iocnt_nxt;
  logic               r_rom_cs, w_rom_cs_nxt;
  logic               r_ram_cs, w_ram_cs_nxt;
  logic               r_in_cs, w_in_cs_nxt;
  logic               r_out_cs, w_out_cs_nxt;
  logic               r_wait_n, w_wait_n_nxt;
  logic               r_rom_en, w_rom_en_nxt;
  logic               r_tmo, w_tmo_nxt;

  logic               w_cycle, w_released, w_inta, w_mem_rd_rom;
  logic [WCNT_W-1:0]  w_mem_wait;
  logic [IOCNT_W-1:0] w_iocnt_inc;

  assign w_cycle      = (!mreq_n || !iorq_n) && (!rd_n || !wr_n);
  assign w_released   = mreq_n && iorq_n;
  assign w_inta       = !m1_n && !iorq_n;
  assign w_mem_rd_rom = !rd_n && (addr <= ROM_TOP) && r_rom_en;
  assign w_iocnt_inc  = r_iocnt + IOCNT_W'(1);

  // Next-state and next-output decode; every registered output defaults to hold.
  always_comb begin
    w_state_nxt  = r_state;
    w_wcnt_nxt   = r_wcnt;
    w_iocnt_nxt  = r_iocnt;
    w_rom_cs_nxt = r_rom_cs;
    w_ram_cs_nxt = r_ram_cs;
    w_in_cs_nxt  = r_in_cs;
    w_out_cs_nxt = r_out_cs;
    w_wait_n_nxt = r_wait_n;
    w_rom_en_nxt = r_rom_en;
    w_tmo_nxt    = r_tmo;
    w_mem_wait   = RAM_WAIT_C;

    case (r_state)
      S_IDLE: begin
        if (w_cycle) begin
          if (w_inta) begin
            w_state_nxt = S_HOLD;
          end else if (!mreq_n) begin
            if (w_mem_rd_rom) begin
              w_rom_cs_nxt = 1'b1;
              w_mem_wait   = ROM_WAIT_C;
            end else begin
              w_ram_cs_nxt = 1'b1;
            end
            if (w_mem_wait != '0) begin
              w_state_nxt  = S_COUNT;
              w_wcnt_nxt   = w_mem_wait;
              w_wait_n_nxt = 1'b0;
            end else begin
              w_state_nxt  = S_HOLD;
            end
          end else if (!wr_n && addr[7:0] == ROM_DIS_PORT) begin
            w_rom_en_nxt = 1'b0;
            w_state_nxt  = S_HOLD;
          end else begin
            w_in_cs_nxt  = !rd_n;
            w_out_cs_nxt = rd_n;
            w_iocnt_nxt  = '0;
            w_wait_n_nxt = 1'b0;
            w_state_nxt  = S_IO_WAIT;
          end
        end
      end

      S_COUNT: begin
        if (w_released) begin
          w_rom_cs_nxt = 1'b0;
          w_ram_cs_nxt = 1'b0;
          w_wait_n_nxt = 1'b1;
          w_wcnt_nxt   = '0;
          w_state_nxt  = S_IDLE;
        end else begin
          w_wcnt_nxt = r_wcnt - WCNT_W'(1);
          if (r_wcnt == WCNT_W'(1)) begin
            w_wait_n_nxt = 1'b1;
            w_state_nxt  = S_HOLD;
          end
        end
      end

      // Ready wins over a timeout landing on the same edge.
      S_IO_WAIT: begin
        if (w_released) begin
          w_in_cs_nxt  = 1'b0;
          w_out_cs_nxt = 1'b0;
          w_wait_n_nxt = 1'b1;
          w_iocnt_nxt  = '0;
          w_state_nxt  = S_IDLE;
        end else if (s100_rdy) begin
          w_wait_n_nxt = 1'b1;
          w_state_nxt  = S_HOLD;
        end else begin
          w_iocnt_nxt = w_iocnt_inc;
          if (w_iocnt_inc == IO_TMO_C) begin
            w_tmo_nxt    = 1'b1;
            w_wait_n_nxt = 1'b1;
            w_state_nxt  = S_HOLD;
          end
        end
      end

      S_HOLD: begin
        if (w_released) begin
          w_rom_cs_nxt = 1'b0;
          w_ram_cs_nxt = 1'b0;
          w_in_cs_nxt  = 1'b0;
          w_out_cs_nxt = 1'b0;
          w_wait_n_nxt = 1'b1;
          w_wcnt_nxt   = '0;
          w_iocnt_nxt  = '0;
          w_state_nxt  = S_IDLE;
        end
      end

      default: begin
        w_rom_cs_nxt = 1'b0;
        w_ram_cs_nxt = 1'b0;
        w_in_cs_nxt  = 1'b0;
        w_out_cs_nxt = 1'b0;
        w_wait_n_nxt = 1'b1;
        w_state_nxt  = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_wcnt   <= '0;
      r_iocnt  <= '0;
      r_rom_cs <= 1'b0;
      r_ram_cs <= 1'b0;
      r_in_cs  <= 1'b0;
      r_out_cs <= 1'b0;
      r_wait_n <= 1'b1;
      r_rom_en <= 1'b1;
      r_tmo    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_wcnt   <= w_wcnt_nxt;
      r_iocnt  <= w_iocnt_nxt;
      r_rom_cs <= w_rom_cs_nxt;
      r_ram_cs <= w_ram_cs_nxt;
      r_in_cs  <= w_in_cs_nxt;
      r_out_cs <= w_out_cs_nxt;
      r_wait_n <= w_wait_n_nxt;
      r_rom_en <= w_rom_en_nxt;
      r_tmo    <= w_tmo_nxt;
    end
  end

  assign rom_cs        = r_rom_cs;
  assign ram_cs        = r_ram_cs;
  assign inPortcon_cs  = r_in_cs;
  assign outPortcon_cs = r_out_cs;
  assign wait_n        = r_wait_n;
  assign rom_enabled   = r_rom_en;
  assign timeout_err   = r_tmo;

endmodule

// File: tb/tb_z80_bus_ctrl.sv
// Bench for z80_bus_ctrl: directed vector table, hand-written reset sequence, and
// randomized transactions checked against a transaction-level expectation model.
module tb_z80_bus_ctrl;

  localparam int T_IO   = 8;
  localparam int W_ROM  = 1;
  localparam int W_RAM  = 0;
  localparam logic [15:0] ROM_TOP = 16'h0FFF;

  localparam int K_MRD = 0, K_MWR = 1, K_IRD = 2, K_IWR = 3, K_INTA = 4;
  localparam logic [3:0] SEL_NONE = 4'b0000, SEL_ROM = 4'b1000, SEL_RAM = 4'b0100,
                         SEL_IN = 4'b0010, SEL_OUT = 4'b0001;

  logic clock = 1'b0;
  logic reset;
  logic [15:0] addr;
  logic mreq_n, iorq_n, rd_n, wr_n, m1_n, s100_rdy;
  logic rom_cs, ram_cs, inPortcon_cs, outPortcon_cs, wait_n, rom_enabled, timeout_err;

  z80_bus_ctrl #(.IO_TIMEOUT(T_IO)) dut (
    .clock(clock), .reset(reset), .addr(addr),
    .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .m1_n(m1_n),
    .s100_rdy(s100_rdy),
    .rom_cs(rom_cs), .ram_cs(ram_cs), .inPortcon_cs(inPortcon_cs),
    .outPortcon_cs(outPortcon_cs), .wait_n(wait_n), .rom_enabled(rom_enabled),
    .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  int n_pass = 0;
  int n_tot  = 0;

  typedef struct {
    int          kind;
    logic [15:0] a;
    int          rdy_d;     // -1: ready never rises
    int          abort_at;  // -1: no early release
    logic [3:0]  exp_sel;
    int          exp_wait;
    bit          exp_rom_en;
    bit          exp_tmo;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [3:0] cur_sel();
    return {rom_cs, ram_cs, inPortcon_cs, outPortcon_cs};
  endfunction

  task automatic idle_bus();
    mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1; s100_rdy = 1'b0;
  endtask

  task automatic drive_txn(input int kind, input logic [15:0] a);
    addr   = a;
    mreq_n = !(kind == K_MRD || kind == K_MWR);
    iorq_n = !(kind == K_IRD || kind == K_IWR || kind == K_INTA);
    rd_n   = !(kind == K_MRD || kind == K_IRD || kind == K_INTA);
    wr_n   = !(kind == K_MWR || kind == K_IWR);
    m1_n   = !(kind == K_INTA);
  endtask

  // One bus transaction: observes each edge from detection until release is complete.
  task automatic run_txn(input int kind, input logic [15:0] a, input int rdy_d,
                         input int abort_at, output int wlo, output logic [3:0] sel_or,
                         output logic [3:0] sel_hold, output int excl_bad,
                         output bit clr_ok, output bit hung);
    bit done;
    logic [3:0] s;
    wlo = 0; sel_or = '0; sel_hold = '0; excl_bad = 0; clr_ok = 1'b0; hung = 1'b0;
    done = 1'b0;
    drive_txn(kind, a);
    s100_rdy = (rdy_d == 0);
    for (int j = 0; j < 300 && !done; j++) begin
      @(posedge clock); #1;
      s = cur_sel();
      if ($countones(s) > 1) excl_bad++;
      if (abort_at >= 0 && j == abort_at) begin
        clr_ok = (s == SEL_NONE) && wait_n;
        done = 1'b1;
      end else begin
        sel_or |= s;
        if (!wait_n) wlo++;
        if (abort_at >= 0 && j + 1 == abort_at) begin
          idle_bus();
        end else if (abort_at < 0 && wait_n) begin
          sel_hold = s;
          done = 1'b1;
        end
        if (!done) s100_rdy = (rdy_d >= 0) && (j + 1 >= rdy_d);
      end
    end
    if (!done) hung = 1'b1;
    if (abort_at < 0 && done) begin
      idle_bus();
      @(posedge clock); #1;
      if ($countones(cur_sel()) > 1) excl_bad++;
      clr_ok = (cur_sel() == SEL_NONE) && wait_n;
    end
    idle_bus();
  endtask

  // Expected outcome of a transaction, from the cycle-type rules.
  task automatic model(input int kind, input logic [15:0] a, input int rdy_d,
                       input int abort_at, inout bit rom_en, inout bit tmo,
                       output logic [3:0] sel, output int w);
    int rdy_at;
    sel = SEL_NONE; w = 0;
    case (kind)
      K_MRD: begin
        if (rom_en && a <= ROM_TOP) begin sel = SEL_ROM; w = W_ROM; end
        else begin sel = SEL_RAM; w = W_RAM; end
      end
      K_MWR: begin sel = SEL_RAM; w = W_RAM; end
      K_INTA: ;
      default: begin
        if (kind == K_IWR && a[7:0] == 8'hE0) rom_en = 1'b0;
        else begin
          sel = (kind == K_IRD) ? SEL_IN : SEL_OUT;
          rdy_at = (rdy_d < 0) ? T_IO + 1 : ((rdy_d < 1) ? 1 : rdy_d);
          if (abort_at >= 0) w = abort_at;
          else if (rdy_at <= T_IO) w = rdy_at;
          else begin w = T_IO; tmo = 1'b1; end
        end
      end
    endcase
  endtask

  task automatic check_txn(input string tag, input int kind, input logic [15:0] a,
                           input int rdy_d, input int abort_at, input logic [3:0] e_sel,
                           input int e_w, input bit e_rom, input bit e_tmo);
    int wlo, xb;
    logic [3:0] so, sh;
    bit clr, hung;
    run_txn(kind, a, rdy_d, abort_at, wlo, so, sh, xb, clr, hung);
    chk({tag, " done"}, 32'(hung), 32'd0);
    chk({tag, " sel"}, 32'(so), 32'(e_sel));
    if (abort_at < 0) chk({tag, " sel_hold"}, 32'(sh), 32'(e_sel));
    chk({tag, " wait_lo"}, 32'(wlo), 32'(e_w));
    chk({tag, " onehot"}, 32'(xb), 32'd0);
    chk({tag, " release"}, 32'(clr), 32'd1);
    chk({tag, " rom_en"}, 32'(rom_enabled), 32'(e_rom));
    chk({tag, " tmo"}, 32'(timeout_err), 32'(e_tmo));
  endtask

  task automatic do_reset();
    reset = 1'b1; idle_bus(); addr = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset sel", 32'(cur_sel()), 32'(SEL_NONE));
    chk("reset wait_n", 32'(wait_n), 32'd1);
    chk("reset rom_en", 32'(rom_enabled), 32'd1);
    chk("reset tmo", 32'(timeout_err), 32'd0);
    reset = 1'b0;
  endtask

  initial begin
    int k, rd, ab, w;
    logic [15:0] a;
    logic [3:0] es;
    bit m_rom, m_tmo;

    vecs[0]  = '{K_MRD,  16'h0100, -1, -1, SEL_ROM,  1,    1, 0};
    vecs[1]  = '{K_MWR,  16'h0100, -1, -1, SEL_RAM,  0,    1, 0};
    vecs[2]  = '{K_MRD,  16'h2000, -1, -1, SEL_RAM,  0,    1, 0};
    vecs[3]  = '{K_MRD,  16'h0FFF, -1, -1, SEL_ROM,  1,    1, 0};
    vecs[4]  = '{K_IRD,  16'h0004, -1,  2, SEL_IN,   2,    1, 0};
    vecs[5]  = '{K_IWR,  16'h00E0, -1, -1, SEL_NONE, 0,    0, 0};
    vecs[6]  = '{K_MRD,  16'h0100, -1, -1, SEL_RAM,  0,    0, 0};
    vecs[7]  = '{K_IRD,  16'h0001,  5, -1, SEL_IN,   5,    0, 0};
    vecs[8]  = '{K_IRD,  16'h0003,  0, -1, SEL_IN,   1,    0, 0};
    vecs[9]  = '{K_INTA, 16'h0000, -1, -1, SEL_NONE, 0,    0, 0};
    vecs[10] = '{K_IWR,  16'h0002, -1, -1, SEL_OUT,  T_IO, 0, 1};
    vecs[11] = '{K_IWR,  16'h00E0, -1, -1, SEL_NONE, 0,    0, 1};

    do_reset();
    for (int i = 0; i < 12; i++)
      check_txn($sformatf("vec%0d", i), vecs[i].kind, vecs[i].a, vecs[i].rdy_d,
                vecs[i].abort_at, vecs[i].exp_sel, vecs[i].exp_wait,
                vecs[i].exp_rom_en, vecs[i].exp_tmo);

    // Reset landing inside an I/O wait after ROM disable and a timeout.
    drive_txn(K_IRD, 16'h0005);
    repeat (3) @(posedge clock);
    #1;
    chk("midrst pre wait_n", 32'(wait_n), 32'd0);
    chk("midrst pre in_cs", 32'(inPortcon_cs), 32'd1);
    reset = 1'b1;
    @(posedge clock); #1;
    chk("midrst sel", 32'(cur_sel()), 32'(SEL_NONE));
    chk("midrst wait_n", 32'(wait_n), 32'd1);
    chk("midrst rom_en", 32'(rom_enabled), 32'd1);
    chk("midrst tmo", 32'(timeout_err), 32'd0);
    reset = 1'b0; idle_bus();
    @(posedge clock); #1;

    m_rom = 1'b1; m_tmo = 1'b0;
    for (int n = 0; n < 80; n++) begin
      k = int'($urandom_range(0, 4));
      a = 16'($urandom);
      if ($urandom_range(0, 1) == 1) a = a & 16'h1FFF;
      if (k == K_IWR && $urandom_range(0, 9) == 0) a[7:0] = 8'hE0;
      rd = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, T_IO - 1));
      ab = -1;
      if ((k == K_IRD || k == K_IWR) && a[7:0] != 8'hE0 && $urandom_range(0, 3) == 0) begin
        w = (rd < 0) ? T_IO : ((rd < 1) ? 1 : rd);
        if (w >= 2) ab = int'($urandom_range(1, w - 1));
      end
      model(k, a, rd, ab, m_rom, m_tmo, es, w);
      check_txn($sformatf("rnd%0d", n), k, a, rd, ab, es, w, m_rom, m_tmo);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
